// File: rtl/seg_mux_capture_pkg.sv
// Shared constants for the multiplexed 7-segment display path: the hex pattern
// table (identical to the encoder's), capture FSM encodings and the accept record.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  // Active-low segments, bit order g..a
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic       hit;
    logic [1:0] slot;
    logic [3:0] nibble;
    logic       dot;
  } accept_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_mux_capture_if.sv
// Multiplexed display pins plus the decoded frame outputs of the capture block.
interface seg_mux_capture_if;
  logic [7:0]  seg_n;
  logic [3:0]  dig_en;
  logic [15:0] value;
  logic [3:0]  dots;
  logic        valid;
  logic        pat_err;
  logic        timeout;

  modport master (
    output seg_n, dig_en,
    input  value, dots, valid, pat_err, timeout
  );

  modport slave (
    input  seg_n, dig_en,
    output value, dots, valid, pat_err, timeout
  );
endinterface

// File: rtl/seg_mux_capture_decode.sv
// Reverse lookup of a 7-segment pattern into its hex nibble; hit=0 when the
// pattern is not one the display encoder can produce.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_mux_capture.sv
// Samples a multiplexed 7-segment bus, waits for each digit strobe to settle,
// decodes it and assembles four digits into a 16-bit frame.
module seg_mux_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 17
) (
  input logic              CLK,
  input logic              RST_N,
  seg_mux_capture_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [11:0] sync1_q, sync1_d;
  logic [11:0] sync2_q, sync2_d;
  logic [11:0] prev_q, prev_d;
  logic [1:0]  state_q, state_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic        acc_valid_q, acc_valid_d;
  accept_t     acc_rec_q, acc_rec_d;

  logic [NUM_DIGITS-1:0][3:0] slot_nib_q, slot_nib_d;
  logic [NUM_DIGITS-1:0]      slot_dot_q, slot_dot_d;
  logic [NUM_DIGITS-1:0]      mask_q, mask_d;
  logic [CNT_W-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  dots_q, dots_d;
  logic        valid_q, valid_d;
  logic        pat_err_q, pat_err_d;
  logic        timeout_q, timeout_d;

  logic       dec_hit;
  logic [3:0] dec_nibble;
  logic       sample_changed;
  logic       sample_onehot;

  seg_pattern_decode u_decode (
    .pattern (sync2_q[6:0]),
    .hit     (dec_hit),
    .nibble  (dec_nibble)
  );

  // sync2_q is the settled sample {dig_en, seg_n}; prev_q is the one before it
  always_comb begin
    sync1_d = {bus.dig_en, bus.seg_n};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // A strobe is accepted exactly once, after STABLE_CYCLES identical one-hot samples
  always_comb begin
    state_d        = state_q;
    stab_cnt_d     = stab_cnt_q;
    acc_valid_d    = 1'b0;
    sample_changed = (sync2_q != prev_q);
    sample_onehot  = is_onehot4(sync2_q[11:8]);
    acc_rec_d      = '{hit:    dec_hit,
                       slot:   onehot_index(sync2_q[11:8]),
                       nibble: dec_nibble,
                       dot:    ~sync2_q[7]};
    case (state_q)
      S_IDLE: begin
        if (sample_onehot) begin
          state_d    = S_COUNT;
          stab_cnt_d = SW'(1);
        end
      end
      S_COUNT: begin
        if (sample_changed) begin
          state_d    = sample_onehot ? S_COUNT : S_IDLE;
          stab_cnt_d = SW'(1);
        end else if (stab_cnt_q == STAB_LAST) begin
          acc_valid_d = 1'b1;
          state_d     = S_HELD;
        end else begin
          stab_cnt_d = stab_cnt_q + SW'(1);
        end
      end
      S_HELD: begin
        if (sample_changed) begin
          state_d    = sample_onehot ? S_COUNT : S_IDLE;
          stab_cnt_d = SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An accept in the same cycle as timeout expiry takes priority
  always_comb begin
    slot_nib_d = slot_nib_q;
    slot_dot_d = slot_dot_q;
    mask_d     = mask_q;
    value_d    = value_q;
    dots_d     = dots_q;
    valid_d    = 1'b0;
    pat_err_d  = 1'b0;
    timeout_d  = 1'b0;
    tmo_cnt_d  = tmo_cnt_q;
    if (acc_valid_q) begin
      tmo_cnt_d = '0;
      if (acc_rec_q.hit) begin
        slot_nib_d[acc_rec_q.slot] = acc_rec_q.nibble;
        slot_dot_d[acc_rec_q.slot] = acc_rec_q.dot;
        mask_d[acc_rec_q.slot]     = 1'b1;
        if (mask_d == '1) begin
          value_d = slot_nib_d;
          dots_d  = slot_dot_d;
          valid_d = 1'b1;
          mask_d  = '0;
        end
      end else begin
        pat_err_d = 1'b1;
      end
    end else if (mask_q != '0) begin
      if (tmo_cnt_q == TMO_LAST) begin
        tmo_cnt_d = '0;
        mask_d    = '0;
        timeout_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      state_q     <= S_IDLE;
      stab_cnt_q  <= '0;
      acc_valid_q <= 1'b0;
      acc_rec_q   <= '0;
      slot_nib_q  <= '0;
      slot_dot_q  <= '0;
      mask_q      <= '0;
      tmo_cnt_q   <= '0;
      value_q     <= '0;
      dots_q      <= '0;
      valid_q     <= 1'b0;
      pat_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      stab_cnt_q  <= stab_cnt_d;
      acc_valid_q <= acc_valid_d;
      acc_rec_q   <= acc_rec_d;
      slot_nib_q  <= slot_nib_d;
      slot_dot_q  <= slot_dot_d;
      mask_q      <= mask_d;
      tmo_cnt_q   <= tmo_cnt_d;
      value_q     <= value_d;
      dots_q      <= dots_d;
      valid_q     <= valid_d;
      pat_err_q   <= pat_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.value   = value_q;
  assign bus.dots    = dots_q;
  assign bus.valid   = valid_q;
  assign bus.pat_err = pat_err_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_seg_mux_capture.sv
// Bench for seg_mux_capture: table-driven frames, hand-written corner sequences
// and a randomized strobe stream checked against a frame-level model.
module tb_seg_mux_capture;

  localparam int STABLE = 4;
  localparam int TMO    = 64;

  logic clk;
  logic rst_n;
  seg_mux_capture_if bus ();

  seg_mux_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (7)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int valid_cnt = 0;
  int pat_cnt = 0;
  int tmo_cnt = 0;
  logic [19:0] valid_log [$];

  logic [6:0] ref_tab [16];

  typedef struct {
    int          order [4];
    logic [6:0]  pat [4];
    logic [3:0]  dot;
    logic [15:0] exp_value;
    logic [3:0]  exp_dots;
    int          exp_valid;
    int          exp_pat;
  } vec_t;

  vec_t vecs [7];

  always @(negedge clk) begin
    if (bus.valid) begin
      valid_cnt++;
      valid_log.push_back({bus.dots, bus.value});
    end
    if (bus.pat_err) pat_cnt++;
    if (bus.timeout) tmo_cnt++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Pins held for 'hold' cycles from a falling edge, then released for 'gap' cycles
  task automatic apply_stimulus(input logic [3:0] en, input logic [6:0] pat,
                                input logic dot, input int hold, input int gap);
    bus.dig_en = en;
    bus.seg_n  = {~dot, pat};
    repeat (hold) @(negedge clk);
    bus.dig_en = 4'b0000;
    bus.seg_n  = 8'hFF;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.dig_en = 4'b0000;
    bus.seg_n  = 8'hFF;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic digit(input int k, input int nib, input logic dot);
    apply_stimulus(4'b0001 << k, ref_tab[nib], dot, 8, 2);
  endtask

  initial begin
    int v0, p0, t0, base;
    logic [6:0] bad;
    logic [3:0] en;
    int hold, nib, rejects, exp_pat;
    logic in_tab, dot;
    logic [3:0] m_nib [4];
    logic [3:0] m_dot;
    logic [3:0] m_mask;
    logic [19:0] exp_q [$];
    logic [15:0] m_val;

    ref_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    vecs[0].order = '{3, 2, 1, 0};
    vecs[0].pat = '{ref_tab[15], ref_tab[2], ref_tab[10], ref_tab[1]};
    vecs[0].dot = 4'b0000; vecs[0].exp_value = 16'h1A2F; vecs[0].exp_dots = 4'b0000;
    vecs[0].exp_valid = 1; vecs[0].exp_pat = 0;
    vecs[1].order = '{0, 2, 3, 1};
    vecs[1].pat = '{ref_tab[15], ref_tab[2], ref_tab[10], ref_tab[1]};
    vecs[1].dot = 4'b0100; vecs[1].exp_value = 16'h1A2F; vecs[1].exp_dots = 4'b0100;
    vecs[1].exp_valid = 1; vecs[1].exp_pat = 0;
    vecs[2].order = '{1, 3, 0, 2};
    vecs[2].pat = '{ref_tab[3], ref_tab[2], ref_tab[1], ref_tab[0]};
    vecs[2].dot = 4'b1001; vecs[2].exp_value = 16'h0123; vecs[2].exp_dots = 4'b1001;
    vecs[2].exp_valid = 1; vecs[2].exp_pat = 0;
    vecs[3].order = '{2, 0, 3, 1};
    vecs[3].pat = '{ref_tab[7], ref_tab[6], ref_tab[5], ref_tab[4]};
    vecs[3].dot = 4'b0010; vecs[3].exp_value = 16'h4567; vecs[3].exp_dots = 4'b0010;
    vecs[3].exp_valid = 1; vecs[3].exp_pat = 0;
    vecs[4].order = '{3, 2, 1, 0};
    vecs[4].pat = '{ref_tab[11], ref_tab[10], ref_tab[9], ref_tab[8]};
    vecs[4].dot = 4'b0000; vecs[4].exp_value = 16'h89AB; vecs[4].exp_dots = 4'b0000;
    vecs[4].exp_valid = 1; vecs[4].exp_pat = 0;
    vecs[5].order = '{0, 1, 2, 3};
    vecs[5].pat = '{ref_tab[15], ref_tab[14], ref_tab[13], ref_tab[12]};
    vecs[5].dot = 4'b1111; vecs[5].exp_value = 16'hCDEF; vecs[5].exp_dots = 4'b1111;
    vecs[5].exp_valid = 1; vecs[5].exp_pat = 0;
    vecs[6].order = '{3, 2, 1, 0};
    vecs[6].pat = '{ref_tab[15], 7'b1111111, ref_tab[10], ref_tab[1]};
    vecs[6].dot = 4'b0000; vecs[6].exp_value = 16'h0000; vecs[6].exp_dots = 4'b0000;
    vecs[6].exp_valid = 0; vecs[6].exp_pat = 1;

    bus.dig_en = 4'b0000;
    bus.seg_n  = 8'hFF;
    rst_n = 1'b0;
    #1;
    check_output("reset_value", 32'(bus.value), 32'h0);
    check_output("reset_dots", 32'(bus.dots), 32'h0);
    check_output("reset_pulses", {29'd0, bus.valid, bus.pat_err, bus.timeout}, 32'h0);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      do_reset();
      v0 = valid_cnt; p0 = pat_cnt;
      for (int j = 0; j < 4; j++) begin
        int k;
        k = vecs[i].order[j];
        apply_stimulus(4'b0001 << k, vecs[i].pat[k], vecs[i].dot[k], 8, 2);
      end
      repeat (10) @(negedge clk);
      check_output($sformatf("vec%0d_valid", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      check_output($sformatf("vec%0d_value", i), 32'(bus.value), 32'(vecs[i].exp_value));
      check_output($sformatf("vec%0d_dots", i), 32'(bus.dots), 32'(vecs[i].exp_dots));
      check_output($sformatf("vec%0d_pat_err", i), 32'(pat_cnt - p0), 32'(vecs[i].exp_pat));
    end

    // Stability threshold: 3 synced cycles rejected, long hold accepted once
    do_reset();
    v0 = valid_cnt;
    digit(2, 10, 1'b0); digit(1, 2, 1'b0); digit(0, 15, 1'b0);
    apply_stimulus(4'b1000, ref_tab[7], 1'b0, 3, 2);
    repeat (10) @(negedge clk);
    check_output("short_hold_no_accept", 32'(valid_cnt - v0), 32'd0);
    apply_stimulus(4'b1000, ref_tab[1], 1'b0, 20, 2);
    repeat (10) @(negedge clk);
    check_output("long_hold_valid", 32'(valid_cnt - v0), 32'd1);
    check_output("long_hold_value", 32'(bus.value), 32'h1A2F);
    digit(2, 3, 1'b0); digit(1, 3, 1'b0); digit(0, 3, 1'b0);
    repeat (10) @(negedge clk);
    check_output("long_hold_single_accept", 32'(valid_cnt - v0), 32'd1);

    // Undecodable pattern leaves the mask alone
    do_reset();
    v0 = valid_cnt; p0 = pat_cnt;
    apply_stimulus(4'b0010, 7'b1111111, 1'b0, 8, 2);
    repeat (5) @(negedge clk);
    check_output("bad_pat_err", 32'(pat_cnt - p0), 32'd1);
    digit(3, 1, 1'b0); digit(2, 10, 1'b0); digit(0, 15, 1'b0);
    repeat (10) @(negedge clk);
    check_output("bad_pat_no_valid", 32'(valid_cnt - v0), 32'd0);
    digit(1, 2, 1'b0);
    repeat (10) @(negedge clk);
    check_output("bad_pat_then_valid", 32'(valid_cnt - v0), 32'd1);
    check_output("bad_pat_value", 32'(bus.value), 32'h1A2F);

    // Two digit enables at once are ignored
    v0 = valid_cnt; p0 = pat_cnt;
    apply_stimulus(4'b0110, ref_tab[5], 1'b1, 10, 2);
    digit(3, 4, 1'b0); digit(0, 4, 1'b0);
    repeat (10) @(negedge clk);
    check_output("multi_en_no_valid", 32'(valid_cnt - v0), 32'd0);
    check_output("multi_en_no_pat", 32'(pat_cnt - p0), 32'd0);
    check_output("multi_en_value_hold", 32'(bus.value), 32'h1A2F);

    // Partial frame times out; value retained
    do_reset();
    digit(3, 1, 1'b0); digit(2, 10, 1'b0); digit(1, 2, 1'b0); digit(0, 15, 1'b1);
    repeat (10) @(negedge clk);
    v0 = valid_cnt; t0 = tmo_cnt;
    digit(3, 12, 1'b0); digit(2, 13, 1'b0);
    repeat (55) @(negedge clk);
    check_output("timeout_not_early", 32'(tmo_cnt - t0), 32'd0);
    repeat (15) @(negedge clk);
    check_output("timeout_pulse", 32'(tmo_cnt - t0), 32'd1);
    check_output("timeout_value_kept", 32'(bus.value), 32'h1A2F);
    digit(1, 0, 1'b0); digit(0, 0, 1'b0);
    repeat (10) @(negedge clk);
    check_output("timeout_mask_cleared", 32'(valid_cnt - v0), 32'd0);

    // Reset mid-frame
    digit(3, 5, 1'b0); digit(2, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("midreset_value", 32'(bus.value), 32'h0);
    check_output("midreset_dots", 32'(bus.dots), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v0 = valid_cnt;
    digit(1, 5, 1'b0); digit(0, 5, 1'b0);
    repeat (10) @(negedge clk);
    check_output("midreset_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Latency of the completing digit: 2 + STABLE + 1 edges
    do_reset();
    digit(3, 9, 1'b0); digit(2, 8, 1'b0); digit(1, 7, 1'b0);
    repeat (8) @(negedge clk);
    bus.dig_en = 4'b0001;
    bus.seg_n  = {1'b1, ref_tab[6]};
    repeat (2 + STABLE) @(negedge clk);
    check_output("latency_not_early", 32'(bus.valid), 32'd0);
    @(negedge clk);
    check_output("latency_valid", 32'(bus.valid), 32'd1);
    check_output("latency_value", 32'(bus.value), 32'h9876);
    @(negedge clk);
    check_output("valid_one_cycle", 32'(bus.valid), 32'd0);
    apply_stimulus(4'b0001, ref_tab[6], 1'b0, 1, 2);

    // Randomized strobe stream against a frame-level model
    do_reset();
    base = valid_log.size(); p0 = pat_cnt; t0 = tmo_cnt;
    m_mask = 4'b0; m_dot = 4'b0; exp_pat = 0; rejects = 0;
    for (int k = 0; k < 4; k++) m_nib[k] = 4'd0;
    exp_q.delete();
    for (int n = 0; n < 80; n++) begin
      int k;
      k = int'($urandom_range(0, 3));
      en = 4'b0001 << k;
      hold = int'($urandom_range(2, 8));
      if (rejects < 3 && $urandom_range(0, 9) == 0) en = 4'b0011 << $urandom_range(0, 2);
      if (rejects >= 3) hold = 8;
      dot = 1'($urandom_range(0, 1));
      nib = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        do begin
          bad = 7'($urandom_range(0, 127));
          in_tab = 1'b0;
          for (int t = 0; t < 16; t++) if (ref_tab[t] == bad) in_tab = 1'b1;
        end while (in_tab);
      end else begin
        bad = ref_tab[nib];
        in_tab = 1'b1;
      end
      apply_stimulus(en, bad, dot, hold, int'($urandom_range(1, 2)));
      if ($countones(en) == 1 && hold >= STABLE) begin
        rejects = 0;
        if (in_tab) begin
          m_nib[k] = 4'(nib);
          m_dot[k] = dot;
          m_mask[k] = 1'b1;
          if (m_mask == 4'hF) begin
            m_val = 16'(m_nib[3] * 4096 + m_nib[2] * 256 + m_nib[1] * 16 + m_nib[0]);
            exp_q.push_back({m_dot, m_val});
            m_mask = 4'b0;
          end
        end else begin
          exp_pat++;
        end
      end else begin
        rejects++;
      end
    end
    repeat (12) @(negedge clk);
    check_output("rand_frame_count", 32'(valid_log.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < valid_log.size())
        check_output($sformatf("rand_frame%0d", i), 32'(valid_log[base + i]), 32'(exp_q[i]));
      else
        check_output($sformatf("rand_frame%0d", i), 32'hFFFFFFFF, 32'(exp_q[i]));
    end
    check_output("rand_pat_err", 32'(pat_cnt - p0), 32'(exp_pat));
    check_output("rand_no_timeout", 32'(tmo_cnt - t0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
